bus_server: RTL

Responder end of the shared request/acknowledge bus: accepts single-word read/write requests from a bus client, services those that fall inside its configured address window, and answers each with a one-cycle `ack` after a programmable number of wait states. It holds a small register-file memory covering its address window and sits on the bus alongside other servers with disjoint windows. Out-of-window requests are left for other servers and receive no response.

---
 rtl/bus_server_if.sv | 26 ++
 rtl/bus_server.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bus_server_if.sv
// Request/acknowledge bus between one client (master) and a responder (slave).
// Request fields flow master->slave; acknowledge, read data and counters flow back.
interface bus_server_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]  address;
    logic                   rq;
    logic                   wr_ni;
    logic [DATA_WIDTH-1:0]  dataW;
    logic                   ack;
    logic [DATA_WIDTH-1:0]  dataR;
    logic [COUNT_WIDTH-1:0] rd_count;
    logic [COUNT_WIDTH-1:0] wr_count;

    modport master (
        output address, rq, wr_ni, dataW,
        input  ack, dataR, rd_count, wr_count
    );

    modport slave (
        input  address, rq, wr_ni, dataW,
        output ack, dataR, rd_count, wr_count
    );
endinterface

// File: rtl/bus_server.sv
// Bus responder owning an address window backed by a small register file; answers
// in-window requests with a one-cycle ack after ACCESS_DELAY wait states.
module bus_server #(
    parameter int DATA_WIDTH           = 8,
    parameter int ADDR_WIDTH           = 4,
    parameter int ADDR_SPACE_BEGINNING = 0,
    parameter int ADDR_SPACE_END       = 3,
    parameter int ACCESS_DELAY         = 2,
    parameter int COUNT_WIDTH          = 8
) (
    input  logic         clk,
    input  logic         reset,
    bus_server_if.slave  bus
);
    localparam int DEPTH  = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_W = (ACCESS_DELAY > 1) ? $clog2(ACCESS_DELAY) : 1;
    localparam int ADDR_MAX = (1 << ADDR_WIDTH) - 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((ACCESS_DELAY > 0) ? ACCESS_DELAY - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_RELEASE
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [WAIT_W-1:0]      r_waitCnt;
    logic [IDX_W-1:0]       r_index;
    logic                   r_isRead;
    logic [DATA_WIDTH-1:0]  r_dataW;
    logic                   r_ack;
    logic [DATA_WIDTH-1:0]  r_dataR;
    logic [COUNT_WIDTH-1:0] r_rdCount;
    logic [COUNT_WIDTH-1:0] r_wrCount;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_geBegin;
    logic                   w_leEnd;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_liveIndex;
    logic                   w_accept;
    logic                   w_enterAck;
    logic                   w_waitInc;
    logic [IDX_W-1:0]       w_opIndex;
    logic                   w_opRead;
    logic [DATA_WIDTH-1:0]  w_opData;

    // Window bounds that cover the whole address range reduce to constants.
    generate
        if (ADDR_SPACE_BEGINNING <= 0) begin : g_geAll
            assign w_geBegin = 1'b1;
        end else begin : g_geCmp
            assign w_geBegin = (bus.address >= ADDR_WIDTH'(ADDR_SPACE_BEGINNING));
        end
        if (ADDR_SPACE_END >= ADDR_MAX) begin : g_leAll
            assign w_leEnd = 1'b1;
        end else begin : g_leCmp
            assign w_leEnd = (bus.address <= ADDR_WIDTH'(ADDR_SPACE_END));
        end
    endgenerate

    assign w_hit       = w_geBegin && w_leEnd;
    assign w_liveIndex = IDX_W'(bus.address - ADDR_WIDTH'(ADDR_SPACE_BEGINNING));

    // With zero wait states the access happens on the accepting edge, so use live fields.
    assign w_opIndex = (r_state == ST_IDLE) ? w_liveIndex : r_index;
    assign w_opRead  = (r_state == ST_IDLE) ? bus.wr_ni   : r_isRead;
    assign w_opData  = (r_state == ST_IDLE) ? bus.dataW   : r_dataW;

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_enterAck  = 1'b0;
        w_waitInc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rq && w_hit) begin
                    w_accept = 1'b1;
                    if (ACCESS_DELAY == 0) begin
                        w_nextState = ST_ACK;
                        w_enterAck  = 1'b1;
                    end else begin
                        w_nextState = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.rq) begin
                    w_nextState = ST_IDLE;
                end else if (r_waitCnt == WAIT_LAST) begin
                    w_nextState = ST_ACK;
                    w_enterAck  = 1'b1;
                end else begin
                    w_waitInc = 1'b1;
                end
            end
            ST_ACK: begin
                w_nextState = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus.rq) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_waitCnt <= '0;
            r_index   <= '0;
            r_isRead  <= 1'b0;
            r_dataW   <= '0;
            r_ack     <= 1'b0;
            r_dataR   <= '0;
            r_rdCount <= '0;
            r_wrCount <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_nextState;
            r_ack   <= w_enterAck;
            if (w_accept) begin
                r_index   <= w_liveIndex;
                r_isRead  <= bus.wr_ni;
                r_dataW   <= bus.dataW;
                r_waitCnt <= '0;
            end else if (w_waitInc) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
            if (w_enterAck) begin
                if (w_opRead) begin
                    r_dataR   <= r_mem[w_opIndex];
                    r_rdCount <= r_rdCount + 1'b1;
                end else begin
                    r_mem[w_opIndex] <= w_opData;
                    r_wrCount        <= r_wrCount + 1'b1;
                end
            end
        end
    end

    assign bus.ack      = r_ack;
    assign bus.dataR    = r_dataR;
    assign bus.rd_count = r_rdCount;
    assign bus.wr_count = r_wrCount;
endmodule
